// File: rtl/biu_data_mem.sv
// Data memory behind the BIU bus: one access per request pulse with WAIT_STATES
// wait cycles. Define BIU_MEM_WRITE_PROTECT_EN to block writes at PROT_BASE and above.
module biu_data_mem #(
    parameter int         DEPTH       = 64,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] PROT_BASE   = 8'hC0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic [7:0] i_Address_Data_Bus,
    input  logic [7:0] i_DataOut_Bus,
    input  logic       W_R,
    output logic [7:0] o_DataIn_Bus,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_addr_err,
    output logic       o_overrun
);

    localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [7:0]  addr_reg;
    logic [7:0]  data_reg;
    logic        wr_reg;

    logic [7:0]  mem [DEPTH];

    logic        in_range;
    logic        prot_hit;
    logic        reject;
    logic [AW-1:0] idx;

    // 9-bit compare so DEPTH=256 still covers every 8-bit address
    assign in_range = ({1'b0, addr_reg} < 9'(DEPTH));
    assign idx      = addr_reg[AW-1:0];

`ifdef BIU_MEM_WRITE_PROTECT_EN
    assign prot_hit = wr_reg && (addr_reg >= PROT_BASE);
`else
    logic unused_prot;
    assign unused_prot = ^PROT_BASE;
    assign prot_hit    = 1'b0;
`endif

    assign reject = !in_range || prot_hit;

    // Memory contents survive reset; a reset forces IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && wr_reg && !reject) begin
            mem[idx] <= data_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            addr_reg     <= 8'h00;
            data_reg     <= 8'h00;
            wr_reg       <= 1'b0;
            o_DataIn_Bus <= 8'h00;
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_addr_err   <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_ready    <= 1'b0;
            o_addr_err <= 1'b0;
            o_overrun  <= i_req && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        addr_reg <= i_Address_Data_Bus;
                        data_reg <= i_DataOut_Bus;
                        wr_reg   <= W_R;
                        wait_cnt <= WS;
                        o_busy   <= 1'b1;
                        state    <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state      <= S_DONE;
                    o_ready    <= 1'b1;
                    o_addr_err <= reject;
                    if (!wr_reg) begin
                        o_DataIn_Bus <= in_range ? mem[idx] : 8'hFF;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_data_mem.sv
// Bench for biu_data_mem: two instances (1 and 0 wait states) share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_biu_data_mem;

    localparam int         DEPTH = 64;
    localparam logic [7:0] PROT  = 8'h30;
    localparam int         WS0   = 1;
    localparam int         WS1   = 0;
`ifdef BIU_MEM_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_req = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] dout = 8'h00;
    logic       W_R = 1'b0;

    logic [7:0] dbus [2];
    logic [1:0] ready, busy, err, ovr;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    biu_data_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS0), .PROT_BASE(PROT)) u_dut0 (
        .clk(clk), .reset(reset), .i_req(i_req),
        .i_Address_Data_Bus(addr), .i_DataOut_Bus(dout), .W_R(W_R),
        .o_DataIn_Bus(dbus[0]), .o_ready(ready[0]), .o_busy(busy[0]),
        .o_addr_err(err[0]), .o_overrun(ovr[0])
    );

    biu_data_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS1), .PROT_BASE(PROT)) u_dut1 (
        .clk(clk), .reset(reset), .i_req(i_req),
        .i_Address_Data_Bus(addr), .i_DataOut_Bus(dout), .W_R(W_R),
        .o_DataIn_Bus(dbus[1]), .o_ready(ready[1]), .o_busy(busy[1]),
        .o_addr_err(err[1]), .o_overrun(ovr[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit rejects(input logic w, input logic [7:0] a);
        return (a >= DEPTH) || (PROT_ON && w && (a >= PROT));
    endfunction

    // Transaction model: a request occupies WS+2 busy cycles; the access lands
    // on the edge that leaves one busy cycle (the strobe cycle) remaining.
    logic [7:0] mmem [2][256];
    int         rem [2];
    logic [7:0] la [2];
    logic [7:0] ld [2];
    logic       lw [2];
    logic [7:0] e_data [2];
    logic       e_ready [2], e_busy [2], e_err [2], e_ovr [2];

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                rem[k]     <= 0;
                e_data[k]  <= 8'h00;
                e_ready[k] <= 1'b0;
                e_busy[k]  <= 1'b0;
                e_err[k]   <= 1'b0;
                e_ovr[k]   <= 1'b0;
            end else begin
                e_ready[k] <= 1'b0;
                e_err[k]   <= 1'b0;
                e_ovr[k]   <= (rem[k] > 0) && i_req;
                if (rem[k] > 0) begin
                    if (rem[k] == 2) begin
                        e_ready[k] <= 1'b1;
                        e_err[k]   <= rejects(lw[k], la[k]);
                        if (lw[k]) begin
                            if (!rejects(lw[k], la[k])) mmem[k][la[k]] <= ld[k];
                        end else begin
                            e_data[k] <= (la[k] < DEPTH) ? mmem[k][la[k]] : 8'hFF;
                        end
                    end
                    rem[k]    <= rem[k] - 1;
                    e_busy[k] <= (rem[k] > 1);
                end else if (i_req) begin
                    la[k]     <= addr;
                    ld[k]     <= dout;
                    lw[k]     <= W_R;
                    rem[k]    <= ((k == 0) ? WS0 : WS1) + 2;
                    e_busy[k] <= 1'b1;
                end else begin
                    e_busy[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cycle_dut%0d {data,rdy,busy,err,ovr}", k),
                      {dbus[k], ready[k], busy[k], err[k], ovr[k]},
                      {e_data[k], e_ready[k], e_busy[k], e_err[k], e_ovr[k]});
            end
        end
    end

    int lat [2];
    int rdy_cnt [2];
    int ovr_cnt [2];
    int busy_cnt [2];
    bit err_seen [2];

    // One request (optionally followed by a second, to-be-dropped one) and an
    // 8-cycle observation window; lat counts cycles after the request cycle.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input bit second);
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; rdy_cnt[k] = 0; ovr_cnt[k] = 0; busy_cnt[k] = 0; err_seen[k] = 0;
        end
        @(negedge clk);
        i_req = 1'b1; W_R = w; addr = a; dout = d;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ready[k]) begin
                    rdy_cnt[k]++;
                    if (lat[k] == 0) lat[k] = n;
                    err_seen[k] = err[k];
                end
                if (ovr[k])  ovr_cnt[k]++;
                if (busy[k]) busy_cnt[k]++;
            end
            if (n == 1) begin
                i_req = second;
                W_R   = 1'($urandom);
                addr  = 8'($urandom);
                dout  = 8'($urandom);
            end else begin
                i_req = 1'b0;
            end
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 cmp_on = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_outputs_dut%0d", k),
                  {dbus[k], ready[k], busy[k], err[k], ovr[k]}, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 8'(i), 8'(i) ^ 8'hA5, 1'b0);
        end
        do_txn(1'b1, 8'h05, 8'h00, 1'b0);

        do_txn(1'b1, 8'h06, 8'h07, 1'b0);
        check("wr_latency_ws1", lat[0], 3);
        check("wr_latency_ws0", lat[1], 2);
        check("wr_err_ws1", int'(err_seen[0]), 0);
        do_txn(1'b0, 8'h06, 8'h00, 1'b0);
        check("rd_latency_ws1", lat[0], 3);
        check("rd_data_ws1", dbus[0], 8'h07);
        check("rd_data_ws0", dbus[1], 8'h07);
        do_txn(1'b1, 8'h10, 8'h11, 1'b0);
        check("rd_data_hold_after_write", dbus[0], 8'h07);

        do_txn(1'b1, 8'h02, 8'h3C, 1'b0);
        do_txn(1'b0, 8'h02, 8'h00, 1'b0);
        check("ws0_rd_latency", lat[1], 2);
        check("ws0_rd_data", dbus[1], 8'h3C);
        check("ws0_busy_cycles", busy_cnt[1], 2);
        check("ws1_busy_cycles", busy_cnt[0], 3);

        do_txn(1'b1, 8'h40, 8'h55, 1'b0);
        check("oor_wr_err_ws1", int'(err_seen[0]), 1);
        check("oor_wr_err_ws0", int'(err_seen[1]), 1);
        do_txn(1'b0, 8'h40, 8'h00, 1'b0);
        check("oor_rd_err", int'(err_seen[0]), 1);
        check("oor_rd_data", dbus[0], 8'hFF);
        do_txn(1'b0, 8'h00, 8'h00, 1'b0);
        check("oor_mem0_intact", dbus[0], 8'hA5);
        check("inrange_rd_err", int'(err_seen[0]), 0);

        do_txn(1'b1, 8'h20, 8'h77, 1'b1);
        check("overrun_pulses_ws1", ovr_cnt[0], 1);
        check("overrun_pulses_ws0", ovr_cnt[1], 1);
        check("overrun_ready_ws1", rdy_cnt[0], 1);
        check("overrun_ready_ws0", rdy_cnt[1], 1);
        do_txn(1'b0, 8'h20, 8'h00, 1'b0);
        check("overrun_first_intact", dbus[0], 8'h77);

        do_txn(1'b1, 8'h30, 8'h99, 1'b0);
        check("prot_wr_err", int'(err_seen[0]), PROT_ON ? 1 : 0);
        do_txn(1'b0, 8'h30, 8'h00, 1'b0);
        check("prot_rd_data", dbus[0], PROT_ON ? 8'h95 : 8'h99);
        check("prot_rd_err", int'(err_seen[0]), 0);

        // Reset while the 1-wait-state instance sits in WAIT
        @(negedge clk);
        i_req = 1'b1; W_R = 1'b1; addr = 8'h05; dout = 8'hAA;
        @(posedge clk);
        #2;
        i_req = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_ready", ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_txn(1'b0, 8'h05, 8'h00, 1'b0);
        check("reset_abandon_ws1", dbus[0], 8'h00);
        check("reset_abandon_ws0", dbus[1], 8'h00);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            i_req = ($urandom_range(0, 2) == 0);
            W_R   = 1'($urandom);
            addr  = 8'($urandom_range(0, 79));
            dout  = 8'($urandom);
        end
        @(negedge clk);
        i_req = 1'b0;
        repeat (8) @(negedge clk);

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
